// File: rtl/mips_shift_pkg.sv
// Shared definitions for the multi-cycle right-shift unit: FSM states and
// default datapath geometry.
package mips_shift_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int SHAMT_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shr_step.sv
// Single-bit right shift: drops the LSB and inserts fill_i at the MSB.
module shr_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] data_o
);

    assign data_o = {fill_i, data_i[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_unit.sv
// Iterative right shifter, one bit per clock, with an IDLE/SHIFT/DONE handshake.
// Sign-fill (arithmetic) shifts exist only when SHIFT_RIGHT_ARITH_EN is defined.
module shift_right_unit
    import mips_shift_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               fill_q;
    logic               accept;
    logic               fillBit;
    logic [WIDTH-1:0]   stepOut;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef SHIFT_RIGHT_ARITH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= 1'b0;
        end else if (accept) begin
            fill_q <= arith;
        end
    end
`else
    logic unusedArith;
    assign unusedArith = arith;
    assign fill_q      = 1'b0;
`endif

    // The MSB never changes during an arithmetic shift, so it still holds the captured sign.
    assign fillBit = fill_q & shift_q[WIDTH-1];

    shr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (shift_q),
        .fill_i (fillBit),
        .data_o (stepOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (count_q == '0) state_d = DONE;
            DONE:    state_d = start ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        count_d = count_q;
        if (accept) begin
            shift_d = operand;
            count_d = shamt;
        end else if ((state_q == SHIFT) && (count_q != '0)) begin
            shift_d = stepOut;
            count_d = count_q - SHAMT_W'(1);
        end
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign result = shift_q;

endmodule

// File: tb/tb_shift_right_unit.sv
// Randomized self-checking bench for shift_right_unit against a plain-arithmetic
// reference; honours SHIFT_RIGHT_ARITH_EN when choosing the expected fill.
module tb_shift_right_unit;

`ifdef SHIFT_RIGHT_ARITH_EN
    localparam bit ARITH_ON = 1'b1;
`else
    localparam bit ARITH_ON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int totalChecks = 0;
    int badChecks   = 0;

    shift_right_unit #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .operand (operand),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] refShift(input logic [31:0] op, input logic [4:0] sh, input logic ar);
        if (ARITH_ON && ar)
            return $signed(op) >>> sh;
        return op >> sh;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a sample point where the DUT accepts on the next rising edge.
    task automatic applyStimulus(input logic [31:0] op, input logic [4:0] sh, input logic ar,
                                 input bit holdStart, input int pulseAt);
        logic [31:0] exp;
        int edges;
        int busyCycles;
        exp     = refShift(op, sh, ar);
        operand = op;
        shamt   = sh;
        arith   = ar;
        start   = 1'b1;
        @(posedge clk); #1;
        if (!holdStart) start = 1'b0;
        operand = $urandom;
        shamt   = 5'($urandom);
        arith   = 1'($urandom);
        edges      = 0;
        busyCycles = 0;
        while (!done && edges < 200) begin
            if (busy) busyCycles++;
            if (edges == pulseAt) start = 1'b1;
            else if (!holdStart) start = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        if (!holdStart) start = 1'b0;
        checkOutput("latency", edges, sh + 1);
        checkOutput("busyCycles", busyCycles, sh + 1);
        checkOutput("result", result, exp);
        checkOutput("busyAtDone", {31'd0, busy}, 32'd0);
        if (!holdStart) begin
            @(posedge clk); #1;
            checkOutput("doneOneCycle", {31'd0, done}, 32'd0);
            checkOutput("idleBusy", {31'd0, busy}, 32'd0);
            checkOutput("resultHeld", result, exp);
        end
    endtask

    task automatic resetMidShift();
        int doneSeen;
        operand = 32'hFFFF_0000;
        shamt   = 5'd10;
        arith   = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("midBusy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstResult", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) doneSeen++;
        end
        checkOutput("noDoneAfterRst", doneSeen, 0);
    endtask

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        operand = '0;
        shamt   = '0;
        arith   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetDone", {31'd0, done}, 32'd0);
        checkOutput("resetResult", result, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h8000_0000, 5'd4, 1'b0, 1'b0, -1);
        applyStimulus(32'h8000_0000, 5'd4, 1'b1, 1'b0, -1);
        checkOutput("arithSign", result, ARITH_ON ? 32'hF800_0000 : 32'h0800_0000);
        applyStimulus(32'h1234_5678, 5'd0, 1'b0, 1'b0, -1);
        applyStimulus(32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, -1);
        checkOutput("maxLogical", result, 32'h0000_0001);
        applyStimulus(32'h8765_4321, 5'd31, 1'b1, 1'b0, -1);

        applyStimulus(32'hDEAD_BEEF, 5'd2, 1'b1, 1'b1, -1);
        applyStimulus(32'hCAFE_F00D, 5'd3, 1'b0, 1'b1, -1);
        applyStimulus(32'hF000_000F, 5'd7, 1'b1, 1'b0, 2);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] sh;
            sh = 5'($urandom);
            applyStimulus($urandom, sh, 1'($urandom), 1'($urandom),
                          (sh > 1) ? int'($urandom_range(0, sh - 1)) : -1);
        end
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        resetMidShift();
        applyStimulus(32'h0F0F_0F0F, 5'd5, 1'b0, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/shift_right_unit.md
SHIFT_RIGHT_UNIT -- requirements
Module: shift_right_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the datapath width in bits.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, meaning the shift-amount width (log2 WIDTH).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Port start  input  1  SHALL request a new shift; it is sampled only when the unit accepts (IDLE or DONE).
REQ-006 Port operand  input  WIDTH  SHALL be the value to shift, captured on acceptance.
REQ-007 Port shamt  input  SHAMT_W  SHALL be the right-shift distance, captured on acceptance.
REQ-008 Port arith  input  1  SHALL select an arithmetic shift (sign fill) when 1 and a logical shift (zero fill) when 0, captured on acceptance.
REQ-009 Port busy  output  1  SHALL be high while a shift is in progress (state SHIFT).
REQ-010 Port done  output  1  SHALL be a one-cycle pulse marking result valid.
REQ-011 Port result  output  WIDTH  SHALL be the shifted value.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 Acceptance SHALL occur on a rising edge where start=1 and the state is IDLE or DONE.
REQ-014 On acceptance, the unit SHALL load operand into the shift register, shamt into the down-counter and arith into the fill-mode flag, and SHALL enter SHIFT.
REQ-015 In SHIFT with count != 0, each edge SHALL shift the register right by one bit, fill the MSB with the captured sign bit (arith=1) or 0 (arith=0), and decrement count.
REQ-016 In SHIFT with count == 0, the next edge SHALL enter DONE without shifting.
REQ-017 Latency SHALL be: done high in the cycle following edge k+shamt+1, where k is the accepting edge (shamt=0 gives done after 2 edges).
REQ-018 DONE SHALL last exactly one cycle and then go to IDLE unless start=1, which SHALL cause acceptance (back-to-back operation).
REQ-019 start while in SHIFT SHALL be ignored, with no queuing.
REQ-020 result SHALL equal the shift register; it is valid from the done cycle until the next acceptance.
REQ-021 The shift SHALL be exact for shamt = WIDTH-1: the logical result is operand>>31, and the arithmetic result is all-ones or all-zeros following the sign.
REQ-022 busy and done SHALL never be high simultaneously.

Reset
REQ-023 Assertion of rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, result=0, count=0 and fill flag=0, including mid-SHIFT; the operation in flight is discarded.
REQ-024 The first edge after deassertion SHALL be able to accept a start.

Configuration
REQ-025 With macro SHIFT_RIGHT_ARITH_EN defined, arith SHALL behave per REQ-008 and REQ-015.
REQ-026 Without SHIFT_RIGHT_ARITH_EN, the arith port SHALL remain present but ignored; all shifts are logical (zero fill) and the fill flag is constant 0.

Structure
REQ-027 The shared package mips_shift_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE), and the WIDTH/SHAMT_W default constants.
REQ-028 One combinational sub-module, shr_step, SHALL perform the single-bit right shift with a fill-bit input; the FSM, counter and registers reside in shift_right_unit.

Verification
REQ-029 Logical shift: operand=0x80000000, shamt=4, arith=0 -> done 5 edges after accept, result=0x08000000, busy high for 5 cycles.
REQ-030 Arithmetic shift (macro on): operand=0x80000000, shamt=4, arith=1 -> result=0xF8000000; with the macro off, the same stimulus gives 0x08000000.
REQ-031 Zero and maximum shift: shamt=0, operand=0x12345678 -> done after 2 edges, result=0x12345678; shamt=31, operand=0xFFFFFFFF, arith=0 -> result=0x00000001.
REQ-032 Back-to-back and ignored start: start held high continuously -> a new acceptance in every DONE cycle; a start pulse during SHIFT -> no effect on result or timing.
REQ-033 Reset mid-operation: rst_n pulsed low at the 3rd SHIFT cycle of shamt=10 -> busy, done and result go to 0 immediately, with no done pulse afterwards until a new start.
